// File: rtl/iter_div_unit_if.sv
// Request/response bundle for the iterative 32-bit divider.
// master = issuing pipeline, slave = divider.
interface iter_div_unit_if;
  logic        div_valid;
  logic        div_ready;
  logic        div_signed;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_cancel;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  modport master (
    output div_valid, div_signed, div_src1, div_src2, div_cancel, res_ready,
    input  div_ready, res_valid, quotient, remainder
  );

  modport slave (
    input  div_valid, div_signed, div_src1, div_src2, div_cancel, res_ready,
    output div_ready, res_valid, quotient, remainder
  );
endinterface

// File: rtl/iter_div_unit.sv
// Iterative restoring divider (DIV/DIVU), one quotient bit per cycle.
// Optional macro DIV_ZERO_BYPASS_EN: divide-by-zero skips CALC and goes straight to FIX.
module iter_div_unit (
  input  logic            clk,
  input  logic            resetn,
  iter_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] wq, wr, dvsr;
  logic        q_neg, r_neg;
  logic [31:0] q_r, r_r;

  logic        accept;
  logic [31:0] abs1, abs2;
  logic [32:0] shifted, diff;
  logic        zero_skip;

  assign accept = bus.div_valid & bus.div_ready & ~bus.div_cancel;
  assign abs1   = (bus.div_signed & bus.div_src1[31]) ? (~bus.div_src1 + 32'd1) : bus.div_src1;
  assign abs2   = (bus.div_signed & bus.div_src2[31]) ? (~bus.div_src2 + 32'd1) : bus.div_src2;

`ifdef DIV_ZERO_BYPASS_EN
  assign zero_skip = (bus.div_src2 == 32'd0);
`else
  assign zero_skip = 1'b0;
`endif

  // wq holds the unconsumed dividend bits and collects quotient bits from the LSB side
  assign shifted = {wr, wq[31]};
  assign diff    = shifted - {1'b0, dvsr};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_skip ? FIX : CALC;
      CALC:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.div_cancel) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      wq    <= '0;
      wr    <= '0;
      dvsr  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      q_r   <= '0;
      r_r   <= '0;
    end else if (accept) begin
      cnt   <= '0;
      dvsr  <= abs2;
      q_neg <= bus.div_signed & (bus.div_src1[31] ^ bus.div_src2[31]);
      r_neg <= bus.div_signed & bus.div_src1[31];
      if (zero_skip) begin
        // same values the full iteration would produce for a zero divisor
        wq <= 32'hFFFF_FFFF;
        wr <= abs1;
      end else begin
        wq <= abs1;
        wr <= '0;
      end
    end else if (state == CALC) begin
      cnt <= cnt + 5'd1;
      if (!diff[32]) begin
        wr <= diff[31:0];
        wq <= {wq[30:0], 1'b1};
      end else begin
        wr <= shifted[31:0];
        wq <= {wq[30:0], 1'b0};
      end
    end else if (state == FIX) begin
      q_r <= q_neg ? (~wq + 32'd1) : wq;
      r_r <= r_neg ? (~wr + 32'd1) : wr;
    end
  end

  assign bus.div_ready = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.quotient  = q_r;
  assign bus.remainder = r_r;

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed self-checking bench for iter_div_unit: results, latency, hold, cancel, reset.
module tb_iter_div_unit;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  iter_div_unit_if dif();

  iter_div_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (dif.slave)
  );

  int total = 0;
  int bad   = 0;

`ifdef DIV_ZERO_BYPASS_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request at negedge; it is accepted on the following posedge (cycle 0).
  task automatic accept_req(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dif.div_valid  = 1'b1;
    dif.div_signed = sgn;
    dif.div_src1   = a;
    dif.div_src2   = b;
    @(posedge clk);
    #1;
    dif.div_valid  = 1'b0;
    dif.div_signed = ~sgn;
    dif.div_src1   = 32'hDEAD_BEEF;
    dif.div_src2   = 32'h1234_5678;
  endtask

  // Latency = index of the edge at which res_valid is first seen high.
  task automatic wait_res(output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!dif.res_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    lat = dif.res_valid ? n + 1 : 0;
  endtask

  task automatic handoff(input string tag);
    dif.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.res_ready = 1'b0;
    chk({tag, "_rdy_after"}, {31'd0, dif.div_ready}, 32'd1);
    chk({tag, "_vld_after"}, {31'd0, dif.res_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input int elat);
    int lat;
    accept_req(sgn, a, b);
    wait_res(lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, dif.quotient, eq);
    chk({tag, "_r"}, dif.remainder, er);
    chk({tag, "_rdy_busy"}, {31'd0, dif.div_ready}, 32'd0);
    handoff(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic seen;
    dif.div_valid  = 1'b0;
    dif.div_signed = 1'b0;
    dif.div_src1   = '0;
    dif.div_src2   = '0;
    dif.div_cancel = 1'b0;
    dif.res_ready  = 1'b0;

    #12;
    chk("rst_q",   dif.quotient,  32'd0);
    chk("rst_r",   dif.remainder, 32'd0);
    chk("rst_vld", {31'd0, dif.res_valid}, 32'd0);
    chk("rst_rdy", {31'd0, dif.div_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    // cancel together with valid in IDLE must not start an operation
    @(negedge clk);
    dif.div_valid  = 1'b1;
    dif.div_cancel = 1'b1;
    dif.div_src1   = 32'd50;
    dif.div_src2   = 32'd5;
    @(posedge clk);
    #1;
    dif.div_valid  = 1'b0;
    dif.div_cancel = 1'b0;
    @(negedge clk);
    chk("cancel_idle_rdy", {31'd0, dif.div_ready}, 32'd1);

    run_op("divu_100_7",   1'b0, 32'd100,       32'd7,         32'h0000_000E, 32'h0000_0002, 34);
    run_op("div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    run_op("div_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 34);
    run_op("div_m10_0",    1'b1, 32'hFFFF_FFF6, 32'd0,         32'h0000_0001, 32'hFFFF_FFF6, ZLAT);
    run_op("divu_5_0",     1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'h0000_0005, ZLAT);
    run_op("divu_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'h0000_0000, 34);
    run_op("div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 34);
    run_op("divu_big_3",   1'b0, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 32'h0000_0002, 34);
    run_op("divu_3_10",    1'b0, 32'd3,         32'd10,        32'h0000_0000, 32'h0000_0003, 34);
    run_op("div_m100_m7",  1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE, 34);

    // result held while the consumer stalls
    accept_req(1'b0, 32'd1000, 32'd9);
    wait_res(lat);
    chk("hold_lat", lat, 34);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_q",   dif.quotient,  32'd111);
      chk("hold_r",   dif.remainder, 32'd1);
      chk("hold_vld", {31'd0, dif.res_valid}, 32'd1);
      chk("hold_rdy", {31'd0, dif.div_ready}, 32'd0);
    end
    handoff("hold");

    // cancel while CALC counter is 10
    accept_req(1'b0, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    dif.div_cancel = 1'b1;
    @(posedge clk);
    #1;
    dif.div_cancel = 1'b0;
    @(negedge clk);
    chk("cancel_rdy", {31'd0, dif.div_ready}, 32'd1);
    chk("cancel_vld", {31'd0, dif.res_valid}, 32'd0);
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34);

    // prime nonzero outputs, then reset while in FIX
    run_op("divu_77_5", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 34);
    accept_req(1'b0, 32'd100, 32'd7);
    repeat (32) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("rstfix_q",   dif.quotient,  32'd0);
    chk("rstfix_r",   dif.remainder, 32'd0);
    chk("rstfix_vld", {31'd0, dif.res_valid}, 32'd0);
    chk("rstfix_rdy", {31'd0, dif.div_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.res_valid) seen = 1'b1;
    end
    chk("rstfix_spurious", {31'd0, seen}, 32'd0);
    chk("rstfix_rdy_after", {31'd0, dif.div_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iter_div_unit.md
ITER_DIV_UNIT -- requirements
Module: iter_div_unit

Interface
REQ-001 The block SHALL be clocked by one clock and reset asynchronously, active-low; port names follow the codebase (clk, resetn).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 div_valid  input  1  request valid; operands and div_signed qualified by it.
REQ-005 div_ready  output  1  high only in IDLE; request accepted on an edge with div_valid&div_ready&~div_cancel.
REQ-006 div_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-007 div_src1  input  32  dividend.
REQ-008 div_src2  input  32  divisor.
REQ-009 div_cancel  input  1  pipeline flush; aborts any operation.
REQ-010 res_valid  output  1  quotient/remainder valid; high only in DONE.
REQ-011 res_ready  input  1  consumer takes result on edge with res_valid&res_ready.
REQ-012 quotient  output  32  registered quotient (LO).
REQ-013 remainder  output  32  registered remainder (HI).

Function
REQ-014 The block SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-015 On accept: latch operands; for signed ops latch magnitudes |src1|, |src2| plus q_neg = s1^s2, r_neg = s1; unsigned ops latch raw operands, q_neg=r_neg=0; iteration counter <= 0; go CALC.
REQ-016 CALC SHALL perform one restoring-division step per cycle (33-bit partial remainder trial subtract, shift in one quotient bit, MSB first) for exactly 32 cycles, counter 0..31; at counter 31 go FIX.
REQ-017 FIX SHALL negate quotient if q_neg and remainder if r_neg (two's complement, 32-bit wrap), register outputs, go DONE.
REQ-018 Latency: accept edge = cycle 0; res_valid SHALL first be high in cycle 34 (32 CALC + 1 FIX).
REQ-019 DONE SHALL hold res_valid, quotient, remainder stable until res_ready edge, then go IDLE; div_ready SHALL be low in DONE, so a new request is accepted no earlier than the cycle after handoff.
REQ-020 Remainder sign SHALL equal dividend sign; |remainder| < |divisor| for nonzero divisor.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-022 Divisor zero SHALL yield magnitude quotient 0xFFFFFFFF and magnitude remainder |src1|, then sign fix per REQ-017 (unsigned: q=0xFFFFFFFF, r=src1; signed: q = s1 ? 0x00000001 : 0xFFFFFFFF, r = src1).
REQ-023 div_cancel high on any edge SHALL force IDLE next cycle, res_valid low, result discarded; cancel with div_valid in IDLE SHALL not accept.
REQ-024 Operand inputs SHALL be ignored outside the accept edge.

Reset
REQ-025 resetn low SHALL immediately force IDLE, counter 0, res_valid 0, div_ready 1 (once IDLE), quotient 0, remainder 0, q_neg/r_neg 0.
REQ-026 Reset asserted mid-CALC/FIX/DONE SHALL abandon the operation; no res_valid after deassert without a new request.

Configuration
REQ-027 Macro DIV_ZERO_BYPASS_EN: when defined, accept with div_src2==0 SHALL skip CALC, go FIX directly with REQ-022 values, res_valid in cycle 2; when undefined, divide-by-zero SHALL run full 34-cycle path; result values SHALL be identical in both builds.

Verification
REQ-028 DIVU 100 / 7 -> cycle 34: quotient 0x0000000E, remainder 0x00000002.
REQ-029 DIV -7 (0xFFFFFFF9) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-030 DIV 0xFFFFFFF6 / 0 -> quotient 0x00000001, remainder 0xFFFFFFF6; latency 34 without DIV_ZERO_BYPASS_EN, 2 with it.
REQ-031 Result held with res_ready low 5 cycles -> outputs stable, div_ready low; res_ready high -> IDLE next cycle, div_ready high.
REQ-032 div_cancel pulsed at CALC counter 10 -> IDLE next cycle, no res_valid; immediate new DIVU 9/3 -> quotient 3, remainder 0 in cycle 34.
REQ-033 resetn pulsed low in FIX -> all outputs 0 asynchronously, div_ready 1 after release, no spurious res_valid.
